adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one saturating two's-complement adder between NREQ requesters.
- Each requester presents an (a, b) operand pair under valid/ready; a round-robin arbiter picks one per cycle.
- The saturated sum is registered into a single output slot, tagged with the requester ID and a saturation flag.
- Sits between the spin-update/energy compute lanes and the shared accumulation datapath.

Parameters:
- NREQ, 4, number of requesters (>=2)
- DATAW, 32, operand/sum width, signed two's complement
- IDW, $clog2(NREQ), requester ID width (derived; not overridden)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NREQ  per-requester operand valid
- req_ready_o  out  NREQ  per-requester accept; one-hot or zero
- req_a_i  in  NREQ*DATAW  operand a, requester k at bits [k*DATAW +: DATAW]
- req_b_i  in  NREQ*DATAW  operand b, same packing
- rsp_valid_o  out  1  result slot valid
- rsp_ready_i  in  1  downstream accepts result
- rsp_sum_o  out  DATAW  saturated sum
- rsp_id_o  out  IDW  index of the requester that produced rsp_sum_o
- rsp_sat_o  out  1  result was clamped (positive or negative)

Behaviour:
- Reset (async, rst_ni=0): rsp_valid_o=0, rsp_sum_o=0, rsp_id_o=0, rsp_sat_o=0, RR pointer=0. Any pending result is dropped. req_ready_o is all-zero while in reset.
- Slot free condition: free = !rsp_valid_o || rsp_ready_i. This gives full throughput: one result per cycle under back-to-back handshakes.
- Arbitration (combinational):
  - Search req_valid_i starting at the RR pointer, wrapping modulo NREQ.
  - The first set index g is granted.
  - req_ready_o[g] = free; all other bits 0. If no request is valid or the slot is not free, req_ready_o = 0.
- Accept (req_valid_i[g] && req_ready_o[g]), evaluated at the next rising edge:
  - rsp_sum_o <= saturated a_g+b_g.
  - rsp_id_o <= g.
  - rsp_sat_o <= overflow.
  - rsp_valid_o <= 1.
  - RR pointer <= (g+1) mod NREQ; g=NREQ-1 wraps to 0.
- Pointer update: the pointer changes only on an accept. A stall or an idle cycle leaves it unchanged.
- Drain without accept: rsp_ready_i=1 and no valid request gives rsp_valid_o <= 0. Output data is held, not cleared.
- Stall: rsp_valid_o=1 and rsp_ready_i=0 hold all rsp_* outputs stable and force req_ready_o=0.
- Arithmetic:
  - Sum computed at DATAW bits.
  - Positive overflow (both operand MSBs 0, wrapped MSB 1) clamps to 2^(DATAW-1)-1.
  - Negative overflow (both MSBs 1, wrapped MSB 0) clamps to -2^(DATAW-1).
  - Mixed signs never overflow.
  - rsp_sat_o=1 only on an actual clamp. Operands whose true sum is exactly max or min give rsp_sat_o=0.
- Latency: exactly 1 cycle from accept to rsp_valid_o.
- Requester protocol: a requester must hold valid and operands stable until ready. The block does not depend on this for correctness, because it samples only on the handshake.

Optional Feature:
- Macro: ADDER_RR_ARB_SATCNT_EN.
- When defined, two ports are added:
  - satcnt_clr_i (in, 1)
  - satcnt_o (out, 16): count of accepted results with overflow.
- Counter behaviour:
  - Reset value 0.
  - Increments on an accept whose overflow=1.
  - Saturates at 16'hFFFF (no wrap).
  - satcnt_clr_i forces 0 next cycle and takes priority over a simultaneous increment.
- When undefined, these ports and the counter logic are absent. Ports and behaviour are otherwise identical.

Decomposition:
- Shared package adder_arb_pkg:
  - SATCNT_W=16 constant
  - function returning DATAW max/min saturation constants
- One natural sub-module: rr_arbiter (NREQ-wide round-robin grant with pointer input and one-hot grant output), reused by other shared resources.
- The saturating adder itself is the existing team adder block, instantiated once. The overflow flag is recomputed locally from the operand MSBs and the wrapped sum MSB.

Test Plan (DATAW=8, NREQ=4 unless noted):
- Single request: req 2 valid, a=10, b=20, rsp_ready_i=1 -> next cycle rsp_valid_o=1, sum=30, id=2, sat=0; pointer=3.
- Round-robin: all 4 valid continuously, rsp_ready_i=1, pointer=0 -> grants 0,1,2,3,0 on consecutive cycles; one result per cycle.
- Saturation: a=100, b=100 -> sum=127, sat=1. a=-100, b=-100 -> sum=-128, sat=1. a=127, b=0 -> sum=127, sat=0. a=-128, b=-1 -> -128, sat=1.
- Back-pressure: result pending, rsp_ready_i=0 for 3 cycles while reqs 0/1 valid -> req_ready_o=0, rsp_* stable, pointer unchanged. Release -> req 1 is granted if the pointer was 1.
- Reset mid-operation: rst_ni low while rsp_valid_o=1 -> rsp_valid_o=0 immediately (async), pointer=0; after release, first grant goes to the lowest valid index.
- With ADDER_RR_ARB_SATCNT_EN: 3 overflow results, then clear asserted concurrently with a 4th overflow accept -> satcnt_o = 3, then 0. Preload to 16'hFFFF via 65535 overflows -> further overflows hold at 16'hFFFF.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared constants and helpers for the shared saturating-adder arbiter.
// Build option: ADDER_RR_ARB_SATCNT_EN adds the saturation event counter.
package adder_arb_pkg;

  localparam int SATCNT_W = 16;

  // Bit pattern of the w-bit two's-complement limit, zero-extended to 64 bits.
  function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
    logic [63:0] msb;
    msb = 64'(1) << (w - 1);
    return neg ? msb : (msb - 64'(1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter: grants the first request at or after ptr_i (wrapping).
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_id_o,
  output logic           grant_any_o
);

  int idx;

  // Scan from the farthest offset back to the pointer so the nearest request wins.
  always_comb begin
    grant_o     = '0;
    grant_id_o  = '0;
    grant_any_o = 1'b0;
    idx         = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_id_o   = IDW'(idx);
        grant_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sat_adder.sv
// Team saturating two's-complement adder: clamps a+b to the W-bit signed range.
module sat_adder
  import adder_arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  localparam logic [63:0] MAX64 = sat_limit(W, 1'b0);
  localparam logic [63:0] MIN64 = sat_limit(W, 1'b1);
  localparam logic [W-1:0] MAX_V = MAX64[W-1:0];
  localparam logic [W-1:0] MIN_V = MIN64[W-1:0];

  logic [W-1:0] wrap;
  logic         pos_ovf;
  logic         neg_ovf;

  assign wrap    = a_i + b_i;
  assign pos_ovf = ~a_i[W-1] & ~b_i[W-1] &  wrap[W-1];
  assign neg_ovf =  a_i[W-1] &  b_i[W-1] & ~wrap[W-1];

  always_comb begin
    sum_o = wrap;
    if (pos_ovf) sum_o = MAX_V;
    else if (neg_ovf) sum_o = MIN_V;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// One saturating adder shared by NREQ requesters via round-robin, single output slot.
// Build option: ADDER_RR_ARB_SATCNT_EN adds satcnt_clr_i/satcnt_o overflow counter.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DATAW = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*DATAW-1:0]   req_a_i,
  input  logic [NREQ*DATAW-1:0]   req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATAW-1:0]        rsp_sum_o,
  output logic [IDW-1:0]          rsp_id_o,
  output logic                    rsp_sat_o
`ifdef ADDER_RR_ARB_SATCNT_EN
  ,
  input  logic                    satcnt_clr_i,
  output logic [SATCNT_W-1:0]     satcnt_o
`endif
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [DATAW-1:0] sum_q, sum_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             sat_q, sat_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic             slot_free;
  logic             accept;
  logic [DATAW-1:0] a_sel, b_sel, wrap, sat_sum;
  logic             ovf;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .grant_any_o (grant_any)
  );

  assign slot_free   = ~valid_q | rsp_ready_i;
  // Gating with rst_ni keeps ready low while reset is held.
  assign req_ready_o = (slot_free && rst_ni) ? grant : '0;
  assign accept      = grant_any & slot_free & rst_ni;

  assign a_sel = req_a_i[grant_id*DATAW +: DATAW];
  assign b_sel = req_b_i[grant_id*DATAW +: DATAW];

  sat_adder #(.W(DATAW)) u_add (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .sum_o (sat_sum)
  );

  // Overflow flag derived locally from operand signs and the wrapped sum sign.
  assign wrap = a_sel + b_sel;
  assign ovf  = (~a_sel[DATAW-1] & ~b_sel[DATAW-1] &  wrap[DATAW-1]) |
                ( a_sel[DATAW-1] &  b_sel[DATAW-1] & ~wrap[DATAW-1]);

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    id_d    = id_q;
    sat_d   = sat_q;
    if (accept) begin
      valid_d = 1'b1;
      sum_d   = sat_sum;
      id_d    = grant_id;
      sat_d   = ovf;
      ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end else if (rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_sum_o   = sum_q;
  assign rsp_id_o    = id_q;
  assign rsp_sat_o   = sat_q;

`ifdef ADDER_RR_ARB_SATCNT_EN
  logic [SATCNT_W-1:0] satcnt_q, satcnt_d;

  always_comb begin
    satcnt_d = satcnt_q;
    if (satcnt_clr_i) satcnt_d = '0;
    else if (accept && ovf && (satcnt_q != '1)) satcnt_d = satcnt_q + SATCNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) satcnt_q <= '0;
    else         satcnt_q <= satcnt_d;
  end

  assign satcnt_o = satcnt_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter (NREQ=4, DATAW=8): driver pushes expected results, monitor pops.
module tb_adder_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int DATAW = 8;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*DATAW-1:0]  req_a_i, req_b_i;
  logic                   rsp_valid_o, rsp_ready_i;
  logic [DATAW-1:0]       rsp_sum_o;
  logic [IDW-1:0]         rsp_id_o;
  logic                   rsp_sat_o;
`ifdef ADDER_RR_ARB_SATCNT_EN
  logic                   satcnt_clr_i;
  logic [15:0]            satcnt_o;
`endif

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NREQ(NREQ), .DATAW(DATAW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_sat_o   (rsp_sat_o)
`ifdef ADDER_RR_ARB_SATCNT_EN
    ,
    .satcnt_clr_i (satcnt_clr_i),
    .satcnt_o     (satcnt_o)
`endif
  );

  typedef struct packed {
    logic [DATAW-1:0] sum;
    logic [IDW-1:0]   id;
    logic             sat;
  } rsp_t;

  rsp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         m_ptr = 0;
  bit         m_valid = 1'b0;
  logic [7:0] a_v[NREQ];
  logic [7:0] b_v[NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum clamped to the signed 8-bit range.
  function automatic rsp_t ref_result(input logic [7:0] a, input logic [7:0] b, input int id);
    rsp_t r;
    int   s;
    s = int'($signed(a)) + int'($signed(b));
    r.id  = IDW'(id);
    r.sat = 1'b0;
    if (s > 127)       begin s = 127;  r.sat = 1'b1; end
    else if (s < -128) begin s = -128; r.sat = 1'b1; end
    r.sum = 8'(s);
    return r;
  endfunction

  // One cycle: drive inputs just after a rising edge, predict, then advance past the next edge.
  task automatic step(input logic [NREQ-1:0] vld, input logic rdy);
    int         g;
    bit         free;
    logic [3:0] exp_ready;
    rsp_t       r;
    req_valid_i = vld;
    rsp_ready_i = rdy;
    for (int k = 0; k < NREQ; k++) begin
      req_a_i[k*DATAW +: DATAW] = a_v[k];
      req_b_i[k*DATAW +: DATAW] = b_v[k];
    end
    #1;
    free = !m_valid || rdy;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_ready = (free && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("req_ready", 32'(req_ready_o), 32'(exp_ready));
    if (free && g >= 0) begin
      r = ref_result(a_v[g], b_v[g], g);
      exp_q.push_back(r);
      $display("accept id=%0d a=%0d b=%0d exp_sum=%0d exp_sat=%0d",
               g, $signed(a_v[g]), $signed(b_v[g]), $signed(r.sum), r.sat);
      m_ptr   = (g + 1) % NREQ;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    a_v[k] = 8'(a);
    b_v[k] = 8'(b);
  endtask

  // Monitor: a result leaves the slot when valid and ready are both high at the edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d sum=%0d expected no response", rsp_id_o, rsp_sum_o);
      end else if (rsp_ready_i) begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_sum", 32'(rsp_sum_o), 32'(e.sum));
        check("rsp_id", 32'(rsp_id_o), 32'(e.id));
        check("rsp_sat", 32'(rsp_sat_o), 32'(e.sat));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    req_a_i     = '0;
    req_b_i     = '0;
`ifdef ADDER_RR_ARB_SATCNT_EN
    satcnt_clr_i = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) set_op(k, 0, 0);

    // Reset state, with all requests asserted.
    req_valid_i = 4'hF;
    #12;
    check("rst_valid", 32'(rsp_valid_o), 0);
    check("rst_sum", 32'(rsp_sum_o), 0);
    check("rst_id", 32'(rsp_id_o), 0);
    check("rst_sat", 32'(rsp_sat_o), 0);
    check("rst_ready", 32'(req_ready_o), 0);
    req_valid_i = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Round robin from pointer 0 with all requesters busy.
    for (int k = 0; k < NREQ; k++) set_op(k, k + 1, 10 * k);
    for (int i = 0; i < 5; i++) step(4'hF, 1'b1);
    step(4'h0, 1'b1);

    // Single request on requester 2.
    set_op(2, 10, 20);
    step(4'b0100, 1'b1);
    step(4'h0, 1'b1);

    // Saturation corners through requester 0.
    set_op(0, 100, 100);  step(4'b0001, 1'b1);
    set_op(0, -100, -100); step(4'b0001, 1'b1);
    set_op(0, 127, 0);    step(4'b0001, 1'b1);
    set_op(0, -128, -1);  step(4'b0001, 1'b1);
    set_op(0, -128, 0);   step(4'b0001, 1'b1);
    set_op(0, 127, -128); step(4'b0001, 1'b1);
    step(4'h0, 1'b1);

    // Back-pressure: pending result held for 3 cycles while 0/1 request.
    set_op(0, 5, 6);
    set_op(1, 7, 8);
    step(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    step(4'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NREQ; k++) set_op(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while a result is pending.
    set_op(3, 1, 2);
    step(4'b1000, 1'b1);
    req_valid_i = 4'b1010;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid_o), 0);
    check("mid_rst_ready", 32'(req_ready_o), 0);
    exp_q.delete();
    m_ptr   = 0;
    m_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_op(1, 3, 4);
    set_op(3, 5, 6);
    step(4'b1010, 1'b1);
    step(4'h0, 1'b1);

`ifdef ADDER_RR_ARB_SATCNT_EN
    // Overflow counter: three overflows, then clear alongside a fourth.
    satcnt_clr_i = 1'b1;
    step(4'h0, 1'b1);
    satcnt_clr_i = 1'b0;
    set_op(0, 100, 100);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1);
    check("satcnt_3", 32'(satcnt_o), 3);
    satcnt_clr_i = 1'b1;
    step(4'b0001, 1'b1);
    satcnt_clr_i = 1'b0;
    check("satcnt_clr", 32'(satcnt_o), 0);
    step(4'h0, 1'b1);
`endif

    // Drain and confirm nothing was lost.
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("final_valid", 32'(rsp_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
